// File: rtl/mem_io_pkg.sv
// Shared encodings for the data-memory / IO access sequencer.
package mem_io_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_CPU, OWN_LD} owner_t;

  localparam logic [21:0] IO_HI    = 22'h3FFFFF;
  localparam logic [3:0]  LED_OFS  = 4'h6;
  localparam logic [3:0]  SW_OFS   = 4'h7;
  localparam logic [3:0]  TUBE_OFS = 4'h8;
endpackage

// File: rtl/mem_io_scheduler_if.sv
// Requester, data-memory and IO signal bundle around the access sequencer.
interface mem_io_scheduler_if;
  import mem_io_pkg::*;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_stall;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_wdata;
  logic [15:0] io_rdata;
  logic        led_cs;
  logic        switch_cs;
  logic        tube_cs;

  // master: the sequencer; slave: the requesters and the memory/IO resources
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_addr, ld_wdata,
           mem_rdata, io_rdata,
    output cpu_rdata, cpu_ack, cpu_stall, ld_ack, mem_en, mem_we, mem_addr,
           mem_wdata, io_rd, io_wr, io_wdata, led_cs, switch_cs, tube_cs
  );
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ld_req, ld_addr, ld_wdata,
           mem_rdata, io_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall, ld_ack, mem_en, mem_we, mem_addr,
           mem_wdata, io_rd, io_wr, io_wdata, led_cs, switch_cs, tube_cs
  );
endinterface

// File: rtl/mem_io_scheduler_io_addr_decoder.sv
// Combinational IO-space and chip-select decode for one access.
module io_addr_decoder #(
  parameter logic [21:0] IO_HI = mem_io_pkg::IO_HI
) (
  input  logic [21:0] page,
  input  logic [3:0]  ofs,
  input  logic        we,
  output logic        is_io,
  output logic        led_cs,
  output logic        switch_cs,
  output logic        tube_cs
);
  import mem_io_pkg::*;

  assign is_io     = (page == IO_HI);
  assign led_cs    = is_io &  we & (ofs == LED_OFS);
  assign switch_cs = is_io & ~we & (ofs == SW_OFS);
  assign tube_cs   = is_io &  we & (ofs == TUBE_OFS);
endmodule

// File: rtl/mem_io_scheduler.sv
// Loader-first arbiter and multi-cycle sequencer for data memory and
// memory-mapped IO; one access in flight, acknowledged by a one-cycle pulse.
module mem_io_scheduler #(
  parameter int unsigned MEM_LAT = 1,
  parameter logic [21:0] IO_HI   = mem_io_pkg::IO_HI
) (
  input logic                clock,
  input logic                reset_n,
  mem_io_scheduler_if.master bus
);
  import mem_io_pkg::*;

  logic        ld_sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        dec_io, dec_led, dec_sw, dec_tube;
  logic        grant_io;

  state_t      state_reg;
  owner_t      owner_reg;
  logic        we_reg;
  logic        is_io_reg;
  logic [2:0]  cnt_reg;
  logic [31:0] cpu_rdata_reg;
  logic        cpu_ack_reg, ld_ack_reg;
  logic        mem_en_reg, mem_we_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg;
  logic        io_rd_reg, io_wr_reg;
  logic [31:0] io_wdata_reg;
  logic        led_cs_reg, switch_cs_reg, tube_cs_reg;

  assign ld_sel    = bus.ld_req;
  assign sel_we    = ld_sel | bus.cpu_we;
  assign sel_addr  = ld_sel ? bus.ld_addr  : bus.cpu_addr;
  assign sel_wdata = ld_sel ? bus.ld_wdata : bus.cpu_wdata;

  io_addr_decoder #(.IO_HI(IO_HI)) u_dec (
    .page      (sel_addr[31:10]),
    .ofs       (sel_addr[7:4]),
    .we        (sel_we),
    .is_io     (dec_io),
    .led_cs    (dec_led),
    .switch_cs (dec_sw),
    .tube_cs   (dec_tube)
  );

  // The loader only ever targets memory, whatever its address looks like.
  assign grant_io = dec_io & ~ld_sel;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_CPU;
      we_reg        <= 1'b0;
      is_io_reg     <= 1'b0;
      cnt_reg       <= 3'd0;
      cpu_rdata_reg <= '0;
      cpu_ack_reg   <= 1'b0;
      ld_ack_reg    <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      io_rd_reg     <= 1'b0;
      io_wr_reg     <= 1'b0;
      io_wdata_reg  <= '0;
      led_cs_reg    <= 1'b0;
      switch_cs_reg <= 1'b0;
      tube_cs_reg   <= 1'b0;
    end else begin
      // strobes, selects and acks are single-cycle pulses
      cpu_rdata_reg <= '0;
      cpu_ack_reg   <= 1'b0;
      ld_ack_reg    <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      io_rd_reg     <= 1'b0;
      io_wr_reg     <= 1'b0;
      io_wdata_reg  <= '0;
      led_cs_reg    <= 1'b0;
      switch_cs_reg <= 1'b0;
      tube_cs_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.ld_req || bus.cpu_req) begin
            owner_reg <= ld_sel ? OWN_LD : OWN_CPU;
            we_reg    <= sel_we;
            is_io_reg <= grant_io;
            state_reg <= ISSUE;
            if (grant_io) begin
              io_rd_reg     <= ~sel_we;
              io_wr_reg     <= sel_we;
              io_wdata_reg  <= sel_wdata;
              led_cs_reg    <= dec_led;
              switch_cs_reg <= dec_sw;
              tube_cs_reg   <= dec_tube;
            end else begin
              mem_en_reg    <= 1'b1;
              mem_we_reg    <= sel_we;
              mem_addr_reg  <= sel_addr;
              mem_wdata_reg <= sel_wdata;
            end
          end
        end
        ISSUE: begin
          if (we_reg) begin
            cpu_ack_reg <= (owner_reg == OWN_CPU);
            ld_ack_reg  <= (owner_reg == OWN_LD);
            state_reg   <= RESP;
          end else if (is_io_reg) begin
            // only the switch offset is readable; anything else reads as zero
            cpu_rdata_reg <= switch_cs_reg ? {{16{bus.io_rdata[15]}}, bus.io_rdata} : '0;
            cpu_ack_reg   <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg   <= 3'(MEM_LAT);
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            cpu_rdata_reg <= bus.mem_rdata;
            cpu_ack_reg   <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.cpu_ack   = cpu_ack_reg;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_reg;
  assign bus.ld_ack    = ld_ack_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.io_rd     = io_rd_reg;
  assign bus.io_wr     = io_wr_reg;
  assign bus.io_wdata  = io_wdata_reg;
  assign bus.led_cs    = led_cs_reg;
  assign bus.switch_cs = switch_cs_reg;
  assign bus.tube_cs   = tube_cs_reg;
endmodule

// File: tb/tb_mem_io_scheduler.sv
// Two sequencers (memory latency 1 and 3) driven by directed and random
// access groups, checked cycle by cycle against a schedule/memory model.
module tb_mem_io_scheduler;
  localparam int NDUT = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam logic [21:0] IO_PAGE = 22'h3FFFFF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n     [NDUT];
  logic        cpu_req   [NDUT];
  logic        cpu_we    [NDUT];
  logic [31:0] cpu_addr  [NDUT];
  logic [31:0] cpu_wdata [NDUT];
  logic        ld_req    [NDUT];
  logic [31:0] ld_addr   [NDUT];
  logic [31:0] ld_wdata  [NDUT];
  logic [15:0] io_rdata  [NDUT];

  logic [31:0] cpu_rdata_o [NDUT];
  logic        cpu_ack_o   [NDUT];
  logic        cpu_stall_o [NDUT];
  logic        ld_ack_o    [NDUT];
  logic        mem_en_o    [NDUT];
  logic        mem_we_o    [NDUT];
  logic [31:0] mem_addr_o  [NDUT];
  logic [31:0] mem_wdata_o [NDUT];
  logic        io_rd_o     [NDUT];
  logic        io_wr_o     [NDUT];
  logic [31:0] io_wdata_o  [NDUT];
  logic        led_o       [NDUT];
  logic        sw_o        [NDUT];
  logic        tube_o      [NDUT];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ref_mem [NDUT][128];

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction
  // memory model storage slot: high-half flag plus word offset
  function automatic int midx(input logic [31:0] a);
    return int'({a[31], a[7:2]});
  endfunction
  function automatic logic [31:0] fill_of(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction
  function automatic string tg(input int d, input int cyc, input string n);
    return $sformatf("d%0d cyc%0d %s", d, cyc, n);
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? LAT0 : LAT1;
    logic [31:0] store [128];
    logic [31:0] pipe  [4];
    mem_io_scheduler_if bus ();

    assign bus.cpu_req   = cpu_req[gi];
    assign bus.cpu_we    = cpu_we[gi];
    assign bus.cpu_addr  = cpu_addr[gi];
    assign bus.cpu_wdata = cpu_wdata[gi];
    assign bus.ld_req    = ld_req[gi];
    assign bus.ld_addr   = ld_addr[gi];
    assign bus.ld_wdata  = ld_wdata[gi];
    assign bus.io_rdata  = io_rdata[gi];
    assign cpu_rdata_o[gi] = bus.cpu_rdata;
    assign cpu_ack_o[gi]   = bus.cpu_ack;
    assign cpu_stall_o[gi] = bus.cpu_stall;
    assign ld_ack_o[gi]    = bus.ld_ack;
    assign mem_en_o[gi]    = bus.mem_en;
    assign mem_we_o[gi]    = bus.mem_we;
    assign mem_addr_o[gi]  = bus.mem_addr;
    assign mem_wdata_o[gi] = bus.mem_wdata;
    assign io_rd_o[gi]     = bus.io_rd;
    assign io_wr_o[gi]     = bus.io_wr;
    assign io_wdata_o[gi]  = bus.io_wdata;
    assign led_o[gi]       = bus.led_cs;
    assign sw_o[gi]        = bus.switch_cs;
    assign tube_o[gi]      = bus.tube_cs;

    // synchronous data memory: read data appears LAT cycles after the enable cycle
    initial for (int i = 0; i < 128; i++) store[i] <= fill_of(i);
    always @(posedge clock) begin
      if (bus.mem_en && bus.mem_we) store[midx(bus.mem_addr)] <= bus.mem_wdata;
      pipe[0] <= (bus.mem_en && !bus.mem_we) ? store[midx(bus.mem_addr)] : 32'hBAD0_BAD0;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    mem_io_scheduler #(.MEM_LAT(LAT), .IO_HI(IO_PAGE)) dut (
      .clock   (clock),
      .reset_n (rst_n[gi]),
      .bus     (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_quiet(input int d, input int cyc, input bit full);
    chk1(tg(d, cyc, "q cpu_ack"), cpu_ack_o[d], 1'b0);
    chk1(tg(d, cyc, "q ld_ack"), ld_ack_o[d], 1'b0);
    chk1(tg(d, cyc, "q cpu_stall"), cpu_stall_o[d], 1'b0);
    chk1(tg(d, cyc, "q mem_en"), mem_en_o[d], 1'b0);
    chk1(tg(d, cyc, "q io_rd"), io_rd_o[d], 1'b0);
    chk1(tg(d, cyc, "q io_wr"), io_wr_o[d], 1'b0);
    chk1(tg(d, cyc, "q led_cs"), led_o[d], 1'b0);
    chk1(tg(d, cyc, "q switch_cs"), sw_o[d], 1'b0);
    chk1(tg(d, cyc, "q tube_cs"), tube_o[d], 1'b0);
    chk(tg(d, cyc, "q cpu_rdata"), cpu_rdata_o[d], 32'h0);
    if (full) begin
      chk1(tg(d, cyc, "q mem_we"), mem_we_o[d], 1'b0);
      chk(tg(d, cyc, "q mem_addr"), mem_addr_o[d], 32'h0);
      chk(tg(d, cyc, "q mem_wdata"), mem_wdata_o[d], 32'h0);
      chk(tg(d, cyc, "q io_wdata"), io_wdata_o[d], 32'h0);
    end
  endtask

  // One access group: optional loader write and/or one CPU access raised together.
  // Cycle 0 is the cycle in which the requests are first sampled.
  task automatic run_group(input int d, input bit ld_on, input logic [31:0] la,
                           input logic [31:0] lw, input bit c_on, input bit cwe,
                           input logic [31:0] ca, input logic [31:0] cw,
                           input logic [15:0] iod, input int c_drop);
    bit c_io;
    int c_lat, ld_iss, ld_ackc, c_iss, c_ackc, start, last, drop_at;
    logic [31:0] exp_rd;
    bit e_ldi, e_ci, e_men, e_mwe, e_ird, e_iwr;
    c_io  = c_on && (ca[31:10] == IO_PAGE);
    c_lat = (cwe || c_io) ? 2 : 2 + lat_of(d);
    ld_iss = -1; ld_ackc = -1; c_iss = -1; c_ackc = -1; start = 0;
    if (ld_on) begin
      ld_iss = 1; ld_ackc = 2; start = 3;
      ref_mem[d][midx(la)] = lw;
    end
    exp_rd = 32'h0;
    if (c_on) begin
      c_iss  = start + 1;
      c_ackc = start + c_lat;
      if (!cwe)
        exp_rd = c_io ? ((ca[7:4] == 4'h7) ? {{16{iod[15]}}, iod} : 32'h0)
                      : ref_mem[d][midx(ca)];
      else if (!c_io)
        ref_mem[d][midx(ca)] = cw;
    end
    drop_at = (c_drop >= 0) ? c_drop : c_ackc;
    last = ((c_ackc > ld_ackc) ? c_ackc : ld_ackc) + 2;
    $display("tx d=%0d ld=%0d la=%h lw=%h cpu=%0d we=%0d ca=%h cw=%h iod=%h cpu_ack@%0d ld_ack@%0d",
             d, ld_on, la, lw, c_on, cwe, ca, cw, iod, c_ackc, ld_ackc);
    @(posedge clock); #1;
    ld_req[d] = ld_on; ld_addr[d] = la; ld_wdata[d] = lw;
    cpu_req[d] = c_on; cpu_we[d] = cwe; cpu_addr[d] = ca; cpu_wdata[d] = cw;
    io_rdata[d] = iod;
    for (int cyc = 0; cyc <= last; cyc++) begin
      @(negedge clock);
      e_ldi = (cyc == ld_iss);
      e_ci  = (cyc == c_iss);
      e_men = e_ldi || (e_ci && !c_io);
      e_mwe = e_ldi || (e_ci && !c_io && cwe);
      e_ird = e_ci && c_io && !cwe;
      e_iwr = e_ci && c_io && cwe;
      chk1(tg(d, cyc, "mem_en"), mem_en_o[d], e_men);
      chk1(tg(d, cyc, "mem_we"), mem_we_o[d], e_mwe);
      if (e_men) chk(tg(d, cyc, "mem_addr"), mem_addr_o[d], e_ldi ? la : ca);
      if (e_mwe) chk(tg(d, cyc, "mem_wdata"), mem_wdata_o[d], e_ldi ? lw : cw);
      chk1(tg(d, cyc, "io_rd"), io_rd_o[d], e_ird);
      chk1(tg(d, cyc, "io_wr"), io_wr_o[d], e_iwr);
      if (e_iwr) chk(tg(d, cyc, "io_wdata"), io_wdata_o[d], cw);
      chk1(tg(d, cyc, "led_cs"), led_o[d], e_iwr && ca[7:4] == 4'h6);
      chk1(tg(d, cyc, "switch_cs"), sw_o[d], e_ird && ca[7:4] == 4'h7);
      chk1(tg(d, cyc, "tube_cs"), tube_o[d], e_iwr && ca[7:4] == 4'h8);
      chk1(tg(d, cyc, "ld_ack"), ld_ack_o[d], cyc == ld_ackc);
      chk1(tg(d, cyc, "cpu_ack"), cpu_ack_o[d], cyc == c_ackc);
      chk(tg(d, cyc, "cpu_rdata"), cpu_rdata_o[d],
          (cyc == c_ackc && !cwe) ? exp_rd : 32'h0);
      chk1(tg(d, cyc, "cpu_stall"), cpu_stall_o[d],
           c_on && cyc < c_ackc && cyc <= drop_at);
      if (cyc == ld_ackc) ld_req[d] = 1'b0;
      if (cyc == drop_at) cpu_req[d] = 1'b0;
    end
  endtask

  int          d_r, kind;
  bit          io_r, we_r;
  logic [31:0] ca_r, la_r;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d] = 1'b0; cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0;
      cpu_wdata[d] = '0; ld_req[d] = 1'b0; ld_addr[d] = '0; ld_wdata[d] = '0;
      io_rdata[d] = '0;
      for (int i = 0; i < 128; i++) ref_mem[d][i] = fill_of(i);
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < NDUT; d++) chk_quiet(d, -1, 1'b1);
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;
    @(negedge clock);

    // latency-1 directed cases
    run_group(0, 0, 0, 0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0, -1);
    run_group(0, 0, 0, 0, 1, 0, 32'h0000_0010, 32'h0, 16'h0, -1);
    run_group(0, 0, 0, 0, 1, 0, 32'hFFFF_FC70, 32'h0, 16'h8001, -1);
    run_group(0, 0, 0, 0, 1, 0, 32'hFFFF_FC70, 32'h0, 16'h7FFE, -1);
    run_group(0, 0, 0, 0, 1, 1, 32'hFFFF_FC60, 32'h0000_1234, 16'h0, -1);
    run_group(0, 0, 0, 0, 1, 1, 32'hFFFF_FC80, 32'h0000_1234, 16'h0, -1);
    run_group(0, 0, 0, 0, 1, 1, 32'hFFFF_FC90, 32'h0000_5678, 16'h0, -1);
    run_group(0, 0, 0, 0, 1, 0, 32'hFFFF_FC60, 32'h0, 16'hFFFF, -1);
    run_group(0, 1, 32'h0000_0020, 32'h1111_2222, 1, 1, 32'h0000_0024, 32'h3333_4444, 16'h0, -1);
    run_group(0, 1, 32'h0000_0028, 32'h5555_6666, 1, 0, 32'h0000_0028, 32'h0, 16'h0, -1);
    run_group(0, 1, 32'hFFFF_FC60, 32'hA1A2_A3A4, 0, 0, 32'h0, 32'h0, 16'h0, -1);
    run_group(0, 0, 0, 0, 1, 1, 32'hFFFF_FBFC, 32'h0BAD_F00D, 16'h0, -1);
    run_group(0, 0, 0, 0, 1, 0, 32'hFFFF_FBFC, 32'h0, 16'h0, -1);
    run_group(0, 0, 0, 0, 1, 0, 32'h0000_0024, 32'h0, 16'h0, 1);

    // latency-3 memory read, then a reset in the middle of WAIT
    run_group(1, 0, 0, 0, 1, 0, 32'h0000_0010, 32'h0, 16'h0, -1);
    run_group(1, 0, 0, 0, 1, 1, 32'h0000_0030, 32'hCAFE_0001, 16'h0, -1);
    $display("tx d=1 reset during WAIT of read 0x30");
    @(posedge clock); #1;
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h0000_0030;
    for (int cyc = 0; cyc <= 3; cyc++) begin
      @(negedge clock);
      if (cyc == 1) chk1(tg(1, cyc, "rst mem_en"), mem_en_o[1], 1'b1);
    end
    rst_n[1] = 1'b0; cpu_req[1] = 1'b0;
    #1 chk_quiet(1, 3, 1'b1);
    @(negedge clock);
    chk_quiet(1, 4, 1'b1);
    rst_n[1] = 1'b1;
    for (int cyc = 5; cyc < 11; cyc++) begin
      @(negedge clock);
      chk_quiet(1, cyc, 1'b0);
    end
    run_group(1, 0, 0, 0, 1, 1, 32'h0000_0034, 32'hCAFE_0002, 16'h0, -1);
    run_group(1, 0, 0, 0, 1, 0, 32'h0000_0030, 32'h0, 16'h0, -1);

    // random access groups on both latencies
    for (int t = 0; t < 60; t++) begin
      d_r  = t % 2;
      kind = int'($urandom_range(0, 2));
      io_r = 1'($urandom_range(0, 1));
      we_r = 1'($urandom_range(0, 1));
      ca_r = io_r ? {IO_PAGE, 10'($urandom)} : {24'h0, 6'($urandom), 2'b00};
      la_r = {24'h0, 6'($urandom), 2'b00};
      run_group(d_r, kind != 1, la_r, $urandom, kind != 0, we_r, ca_r, $urandom,
                16'($urandom), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
